// File: rtl/invader_blitter.sv
// Framebuffer writer for the invader formation: clears the previous 176x80
// bounding box, then rasterises 55 16x16 invader cells at the new origin.
module invader_blitter #(
  parameter int unsigned FB_W = 320,
  parameter int unsigned FB_H = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  base_x,
  input  logic [7:0]  base_y,
  input  logic [54:0] killed,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [8:0]  wr_x,
  output logic [7:0]  wr_y,
  output logic        wr_bit,
  output logic        busy,
  output logic        done
);

  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;
  localparam int unsigned NINV = 55;
  localparam logic [9:0] FB_W_L = 10'(FB_W);
  localparam logic [8:0] FB_H_L = 9'(FB_H);
  localparam logic [7:0] CLR_X_LAST = 8'd175;
  localparam logic [6:0] CLR_Y_LAST = 7'd79;
  localparam logic [3:0] CELL_LAST = 4'd15;
  localparam logic [3:0] COL_LAST = 4'd10;
  localparam logic [2:0] ROW_LAST = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   prev_x_q, prev_x_d;
  logic [YW-1:0]   prev_y_q, prev_y_d;
  logic [XW-1:0]   base_x_q, base_x_d;
  logic [YW-1:0]   base_y_q, base_y_d;
  logic [NINV-1:0] killed_q, killed_d;
  logic [7:0]      cx_q, cx_d;
  logic [6:0]      cy_q, cy_d;
  logic [3:0]      sx_q, sx_d;
  logic [3:0]      sy_q, sy_d;
  logic [3:0]      col_q, col_d;
  logic [2:0]      row_q, row_d;
  logic            wr_en_q, wr_en_d;
  logic [XW-1:0]   wr_x_q, wr_x_d;
  logic [YW-1:0]   wr_y_q, wr_y_d;
  logic            wr_bit_q, wr_bit_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            step;
  logic            advance;
  logic            draw_last;
  logic [9:0]      pos_x;
  logic [8:0]      pos_y;
  logic [5:0]      inv_idx;
  logic [3:0]      sprite_w;
  logic            pix_bit;

  // Sequencer: advance on an accepted beat or a clipped (non-written) position,
  // then present the pixel for the new position in the same edge.
  always_comb begin
    state_d  = state_q;
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    killed_d = killed_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    col_d    = col_q;
    row_d    = row_q;
    wr_en_d  = wr_en_q;
    wr_x_d   = wr_x_q;
    wr_y_d   = wr_y_q;
    wr_bit_d = wr_bit_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    step     = 1'b0;
    advance  = !wr_en_q || wr_ready;
    draw_last = (sx_q == CELL_LAST) && (sy_q == CELL_LAST) &&
                (col_q == COL_LAST) && (row_q == ROW_LAST);

    case (state_q)
      S_IDLE: begin
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          state_d  = S_CLEAR;
          base_x_d = base_x;
          base_y_d = base_y;
          killed_d = killed;
          cx_d     = 8'd0;
          cy_d     = 7'd0;
          busy_d   = 1'b1;
          step     = 1'b1;
        end
      end
      S_CLEAR: begin
        if (advance) begin
          step = 1'b1;
          if (cx_q == CLR_X_LAST) begin
            cx_d = 8'd0;
            if (cy_q == CLR_Y_LAST) begin
              cy_d    = 7'd0;
              state_d = S_DRAW;
              sx_d    = 4'd0;
              sy_d    = 4'd0;
              col_d   = 4'd0;
              row_d   = 3'd0;
            end else begin
              cy_d = cy_q + 7'd1;
            end
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
      end
      S_DRAW: begin
        if (advance) begin
          if (draw_last) begin
            state_d  = S_DONE;
            wr_en_d  = 1'b0;
            wr_bit_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            prev_x_d = base_x_q;
            prev_y_d = base_y_q;
          end else begin
            step = 1'b1;
            if (sx_q != CELL_LAST) begin
              sx_d = sx_q + 4'd1;
            end else begin
              sx_d = 4'd0;
              if (sy_q != CELL_LAST) begin
                sy_d = sy_q + 4'd1;
              end else begin
                sy_d = 4'd0;
                if (col_q != COL_LAST) begin
                  col_d = col_q + 4'd1;
                end else begin
                  col_d = 4'd0;
                  row_d = row_q + 3'd1;
                end
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Position and sprite pixel for the newly selected counters.
    if (state_d == S_DRAW) begin
      pos_x = {1'b0, base_x_q} + {2'b00, col_d, 4'b0000} + {6'b000000, sx_d};
      pos_y = {1'b0, base_y_q} + {2'b00, row_d, 4'b0000} + {5'b00000, sy_d};
    end else begin
      pos_x = {1'b0, prev_x_q} + {2'b00, cx_d};
      pos_y = {1'b0, prev_y_q} + {2'b00, cy_d};
    end
    inv_idx  = 6'(row_d) * 6'd11 + 6'(col_d);
    sprite_w = (row_d == 3'd0) ? 4'd8 : ((row_d < 3'd3) ? 4'd11 : 4'd12);
    pix_bit  = !killed_q[inv_idx] && (sy_d >= 4'd8) && (sx_d < sprite_w);

    if (step) begin
      wr_en_d  = (pos_x < FB_W_L) && (pos_y < FB_H_L);
      wr_x_d   = pos_x[XW-1:0];
      wr_y_d   = pos_y[YW-1:0];
      wr_bit_d = (state_d == S_DRAW) && pix_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prev_x_q <= '0;
      prev_y_q <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      killed_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_x_q   <= '0;
      wr_y_q   <= '0;
      wr_bit_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      killed_q <= killed_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      col_q    <= col_d;
      row_q    <= row_d;
      wr_en_q  <= wr_en_d;
      wr_x_q   <= wr_x_d;
      wr_y_q   <= wr_y_d;
      wr_bit_q <= wr_bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign wr_en  = wr_en_q;
  assign wr_x   = wr_x_q;
  assign wr_y   = wr_y_q;
  assign wr_bit = wr_bit_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_invader_blitter.sv
// Scoreboard bench for invader_blitter: expected beats are queued at start,
// a negedge monitor pops and compares every accepted write.
module tb_invader_blitter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  base_x;
  logic [7:0]  base_y;
  logic [54:0] killed;
  logic        wr_ready;
  logic        wr_en;
  logic [8:0]  wr_x;
  logic [7:0]  wr_y;
  logic        wr_bit;
  logic        busy;
  logic        done;

  invader_blitter #(.FB_W(320), .FB_H(200)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_x(base_x), .base_y(base_y),
    .killed(killed), .wr_ready(wr_ready), .wr_en(wr_en), .wr_x(wr_x),
    .wr_y(wr_y), .wr_bit(wr_bit), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int b;
    bit d;
  } beat_t;

  beat_t exp_q[$];
  int    done_q[$];
  int    drawn[int];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    frame_id = 0;
  int    seen_id = 0;
  int    fb = 0;
  int    wr_seen = 0;
  int    clear_n = 0;
  int    clear_ones = 0;
  int    first_x = -1, first_y = -1, last_x = -1, last_y = -1;
  int    mprev_x = 0, mprev_y = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int pos_now();
    return int'(wr_x) * 256 + int'(wr_y);
  endfunction

  function automatic int pix(input int x, input int y);
    return drawn.exists(x * 256 + y) ? drawn[x * 256 + y] : -1;
  endfunction

  // Reference stream of accepted beats for one redraw (clipped positions omitted).
  task automatic push_frame(input int px, input int py, input int bx, input int by,
                            input logic [54:0] kl);
    beat_t e;
    for (int oy = 0; oy < 80; oy++)
      for (int ox = 0; ox < 176; ox++) begin
        e.x = px + ox; e.y = py + oy; e.b = 0; e.d = 1'b0;
        if (e.x < 320 && e.y < 200) exp_q.push_back(e);
      end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 11; c++)
        for (int sy = 0; sy < 16; sy++)
          for (int sx = 0; sx < 16; sx++) begin
            int w;
            w = (r == 0) ? 8 : ((r < 3) ? 11 : 12);
            e.x = bx + 16 * c + sx; e.y = by + 16 * r + sy; e.d = 1'b1;
            e.b = (!kl[r * 11 + c] && sy >= 8 && sx < w) ? 1 : 0;
            if (e.x < 320 && e.y < 200) exp_q.push_back(e);
          end
  endtask

  task automatic start_frame(input int bx, input int by, input logic [54:0] kl,
                             output int k);
    base_x = 9'(bx);
    base_y = 8'(by);
    killed = kl;
    push_frame(mprev_x, mprev_y, bx, by, kl);
    frame_id++;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int g;
    g = 0;
    while (done_q.size() == 0 && g < 40000) begin
      tick(1);
      g++;
    end
    tick(3);
    chk({tag, "_done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) chk({tag, "_done_cycle"}, done_q[0], exp_cyc);
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    done_q.delete();
  endtask

  // Monitor: pop one expectation per accepted beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (frame_id != seen_id) begin
        seen_id = frame_id;
        fb = 0; clear_n = 0; clear_ones = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        drawn.delete();
      end
      if (rst_n && wr_en) wr_seen++;
      if (rst_n && wr_en && wr_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got (%0d,%0d) bit %0d, want no write", wr_x, wr_y, wr_bit);
        end else begin
          e = exp_q.pop_front();
          if (int'(wr_x) != e.x || int'(wr_y) != e.y || int'(wr_bit) != e.b) begin
            bad++;
            $display("FAIL beat %0d: got (%0d,%0d) bit %0d, want (%0d,%0d) bit %0d",
                     fb, wr_x, wr_y, wr_bit, e.x, e.y, e.b);
          end
          if (e.d) begin
            drawn[int'(wr_x) * 256 + int'(wr_y)] = int'(wr_bit);
          end else begin
            if (clear_n == 0) begin first_x = int'(wr_x); first_y = int'(wr_y); end
            last_x = int'(wr_x); last_y = int'(wr_y);
            if (wr_bit) clear_ones++;
            clear_n++;
          end
        end
        fb++;
      end
      if (done) done_q.push_back(cyc);
    end
  end

  initial begin
    int k, g, s0, ones, seen;
    rst_n = 1'b1; start = 1'b0; base_x = '0; base_y = '0; killed = '0; wr_ready = 1'b1;
    #3 rst_n = 1'b0;

    // Reset held with start toggling.
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      tick(1);
      chk("reset_quiet", {29'd0, wr_en, busy, done}, 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    s0 = wr_seen;
    tick(1000);
    chk("idle_no_writes", wr_seen - s0, 0);

    // Frame 1: nominal origin, backpressure at (12,30), ignored start mid-redraw.
    start_frame(8, 20, '0, k);
    chk("f1_first_pos", pos_now(), 0);
    chk("f1_first_busy", int'(busy), 1);
    chk("f1_first_en", int'(wr_en), 1);
    base_x = 9'd100; base_y = 8'd3; killed = '1;
    g = 0;
    while (!(cyc >= k + 14080 && wr_en && wr_x == 9'd12 && wr_y == 8'd30) && g < 20000) begin
      tick(1);
      g++;
    end
    wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold_pos", pos_now(), 12 * 256 + 30);
      chk("bp_hold_bit", {30'd0, wr_en, wr_bit}, 3);
      if (i < 5) tick(1);
    end
    wr_ready = 1'b1;
    while (cyc < k + 20000) tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("f1", k + 28160 + 5);
    mprev_x = 8; mprev_y = 20;
    chk("f1_clear_count", clear_n, 14080);
    chk("f1_clear_ones", clear_ones, 0);
    chk("f1_clear_first", first_x * 256 + first_y, 0);
    chk("f1_clear_last", last_x * 256 + last_y, 175 * 256 + 79);
    chk("f1_px_8_20", pix(8, 20), 0);
    chk("f1_px_8_28", pix(8, 28), 1);
    chk("f1_px_15_28", pix(15, 28), 1);
    chk("f1_px_16_28", pix(16, 28), 0);
    chk("f1_px_19_76", pix(19, 76), 1);
    chk("f1_px_20_76", pix(20, 76), 0);

    // Frame 2: invader 0 killed, origin moved by one pixel, no stalls.
    start_frame(9, 20, 55'd1, k);
    chk("f2_first_pos", pos_now(), 8 * 256 + 20);
    chk("f2_first_busy", int'(busy), 1);
    wait_done("f2", k + 28160);
    mprev_x = 9; mprev_y = 20;
    chk("f2_clear_first", first_x * 256 + first_y, 8 * 256 + 20);
    ones = 0; seen = 0;
    for (int x = 9; x < 25; x++)
      for (int y = 20; y < 36; y++) begin
        if (pix(x, y) >= 0) seen++;
        if (pix(x, y) == 1) ones++;
      end
    chk("f2_inv0_count", seen, 256);
    chk("f2_inv0_ones", ones, 0);
    chk("f2_px_25_28", pix(25, 28), 1);

    // Frame 3: origin near the bottom-right corner, clipping with wr_ready low.
    start_frame(300, 190, '0, k);
    chk("f3_first_pos", pos_now(), 9 * 256 + 20);
    g = 0;
    while (!(busy && !wr_en) && g < 20000) begin
      tick(1);
      g++;
    end
    chk("clip_first_pos", pos_now(), 300 * 256 + 200);
    wr_ready = 1'b0;
    for (int j = 1; j < 96; j++) begin
      tick(1);
      chk("clip_adv_en", int'(wr_en), 0);
      chk("clip_adv_pos", pos_now(), (300 + j % 16) * 256 + 200 + j / 16);
    end
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk("clip_stall_en", int'(wr_en), 1);
      chk("clip_stall_pos", pos_now(), 316 * 256 + 190);
      tick(1);
    end
    wr_ready = 1'b1;
    while (cyc < k + 20000) tick(1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {14'd0, wr_en, busy, done, wr_bit, wr_x, wr_y}, 0);
    chk("abort_no_done", done_q.size(), 0);
    exp_q.delete();
    mprev_x = 0; mprev_y = 0;
    tick(3);
    rst_n = 1'b1;
    s0 = wr_seen;
    tick(1000);
    chk("post_abort_no_writes", wr_seen - s0, 0);

    // Frame 4: clear must restart from the reset origin (0,0).
    start_frame(8, 20, '0, k);
    chk("f4_first_pos", pos_now(), 0);
    tick(300);
    chk("f4_beats", fb, 300);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
